// File: rtl/bullet_pkg.sv
// Shared types and constants for the player's bullet pool: scheduler FSM states,
// one-hot ship directions and the ship centre used by the bullet units.
package bullet_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam int Ship_Center_X = 320;
  localparam int Ship_Center_Y = 240;

endpackage

// File: rtl/bullet_scheduler_rr_slot_picker.sv
// Round-robin free-slot finder: returns the first free slot strictly after
// rr_ptr, scanning upward and wrapping, so rr_ptr itself is checked last.
module rr_slot_picker #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0]         free_mask,
  input  logic [$clog2(NUM_SLOTS)-1:0] rr_ptr,
  output logic                         found,
  output logic [$clog2(NUM_SLOTS)-1:0] index
);
  import bullet_pkg::*;

  localparam int PTR_W = $clog2(NUM_SLOTS);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_SLOTS; i >= 1; i--) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_SLOTS);
      if (free_mask[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Turns fire-button presses into one-frame shoot pulses for a free bullet slot,
// with round-robin slot choice, a post-shot cooldown and a short pending window.
module bullet_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PENDING_FRAMES  = 4
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 fire_btn,
  input  logic [3:0]           direction,
  input  logic [NUM_SLOTS-1:0] slot_exists,
  output logic [NUM_SLOTS-1:0] shoot_bullet,
  output logic [3:0]           shot_direction,
  output logic                 busy,
  output logic [15:0]          shots_fired,
  output logic [7:0]           dropped_shots
);
  import bullet_pkg::*;

  localparam int PTR_W   = $clog2(NUM_SLOTS);
  localparam int CNT_MAX = (COOLDOWN_FRAMES > PENDING_FRAMES) ? COOLDOWN_FRAMES : PENDING_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic                 fire_prev_q, fire_prev_d;
  logic [3:0]           last_dir_q, last_dir_d;
  logic [3:0]           shot_dir_q, shot_dir_d;
  logic [NUM_SLOTS-1:0] shoot_q, shoot_d;
  logic [NUM_SLOTS-1:0] shoot_prev_q, shoot_prev_d;
  logic [15:0]          shots_q, shots_d;
  logic [7:0]           dropped_q, dropped_d;

  logic                 press;
  logic                 do_fire;
  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic [NUM_SLOTS-1:0] free_mask;

  assign press = fire_btn & ~fire_prev_q;
  // A freshly pulsed slot stays reserved one extra frame until its exists flag rises.
  assign free_mask = ~slot_exists & ~(shoot_q | shoot_prev_q);

  rr_slot_picker #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_picker (
    .free_mask(free_mask),
    .rr_ptr   (rr_q),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rr_d         = rr_q;
    fire_prev_d  = fire_btn;
    last_dir_d   = $onehot(direction) ? direction : last_dir_q;
    shot_dir_d   = shot_dir_q;
    shoot_d      = '0;
    shoot_prev_d = shoot_q;
    shots_d      = shots_q;
    dropped_d    = dropped_q;
    do_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (press) begin
          if (pick_found) begin
            do_fire = 1'b1;
          end else begin
            state_d = PENDING;
            count_d = CNT_W'(PENDING_FRAMES);
          end
        end
      end
      PENDING: begin
        if (pick_found) begin
          do_fire = 1'b1;
        end else if (count_q <= CNT_W'(1)) begin
          state_d = IDLE;
          count_d = '0;
          if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (count_q <= CNT_W'(1)) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_fire) begin
      shoot_d[pick_idx] = 1'b1;
      shot_dir_d        = last_dir_d;
      rr_d              = pick_idx;
      shots_d           = shots_q + 16'd1;
      state_d           = COOLDOWN;
      count_d           = CNT_W'(COOLDOWN_FRAMES);
    end
  end

  // fire_prev resets high so a button held through reset cannot count as a press.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rr_q         <= PTR_W'(NUM_SLOTS - 1);
      fire_prev_q  <= 1'b1;
      last_dir_q   <= DIR_UP;
      shot_dir_q   <= DIR_UP;
      shoot_q      <= '0;
      shoot_prev_q <= '0;
      shots_q      <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      fire_prev_q  <= fire_prev_d;
      last_dir_q   <= last_dir_d;
      shot_dir_q   <= shot_dir_d;
      shoot_q      <= shoot_d;
      shoot_prev_q <= shoot_prev_d;
      shots_q      <= shots_d;
      dropped_q    <= dropped_d;
    end
  end

  assign shoot_bullet   = shoot_q;
  assign shot_direction = shot_dir_q;
  assign busy           = (state_q != IDLE);
  assign shots_fired    = shots_q;
  assign dropped_shots  = dropped_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler and its round-robin picker: a vector table
// for the basic fire/cooldown timeline plus hand sequences for multi-cycle cases.
module tb_bullet_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        fire_btn = 1'b0;
  logic [3:0]  direction = 4'b0001;
  logic [3:0]  slot_exists = 4'b0000;
  logic [3:0]  shoot_bullet;
  logic [3:0]  shot_direction;
  logic        busy;
  logic [15:0] shots_fired;
  logic [7:0]  dropped_shots;

  logic [3:0]  pk_mask = 4'b0000;
  logic [1:0]  pk_ptr = 2'd0;
  logic        pk_found;
  logic [1:0]  pk_idx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        fire;
    logic [3:0]  dir;
    logic [3:0]  exists;
    logic [3:0]  shoot;
    logic [3:0]  sdir;
    logic        busy;
    logic [15:0] shots;
    logic [7:0]  dropped;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] ptr;
    logic       found;
    logic [1:0] idx;
  } pick_vec_t;

  vec_t      vecs[12];
  pick_vec_t pvecs[7];

  bullet_scheduler #(
    .NUM_SLOTS(4),
    .COOLDOWN_FRAMES(8),
    .PENDING_FRAMES(4)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .fire_btn      (fire_btn),
    .direction     (direction),
    .slot_exists   (slot_exists),
    .shoot_bullet  (shoot_bullet),
    .shot_direction(shot_direction),
    .busy          (busy),
    .shots_fired   (shots_fired),
    .dropped_shots (dropped_shots)
  );

  rr_slot_picker #(
    .NUM_SLOTS(4)
  ) picker (
    .free_mask(pk_mask),
    .rr_ptr   (pk_ptr),
    .found    (pk_found),
    .index    (pk_idx)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Inputs change just after an edge; outputs are read just after the next one.
  task automatic applyStimulus(input logic btn, input logic [3:0] dir, input logic [3:0] ex);
    fire_btn    = btn;
    direction   = dir;
    slot_exists = ex;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] e_shoot, input logic [3:0] e_dir,
                          input logic e_busy, input logic [15:0] e_shots, input logic [7:0] e_drop);
    checkOutput({tag, ".shoot"}, 16'(shoot_bullet), 16'(e_shoot));
    checkOutput({tag, ".dir"}, 16'(shot_direction), 16'(e_dir));
    checkOutput({tag, ".busy"}, 16'(busy), 16'(e_busy));
    checkOutput({tag, ".shots"}, shots_fired, e_shots);
    checkOutput({tag, ".dropped"}, 16'(dropped_shots), 16'(e_drop));
  endtask

  task automatic doReset(input logic btn, input logic [3:0] dir);
    Reset    = 1'b1;
    fire_btn = btn;
    direction = dir;
    slot_exists = 4'b0000;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [3:0] first_pulse;

    pvecs[0] = '{4'b1111, 2'd3, 1'b1, 2'd0};
    pvecs[1] = '{4'b1111, 2'd0, 1'b1, 2'd1};
    pvecs[2] = '{4'b0001, 2'd0, 1'b1, 2'd0};
    pvecs[3] = '{4'b0000, 2'd2, 1'b0, 2'd0};
    pvecs[4] = '{4'b1000, 2'd1, 1'b1, 2'd3};
    pvecs[5] = '{4'b0110, 2'd2, 1'b1, 2'd1};
    pvecs[6] = '{4'b0101, 2'd0, 1'b1, 2'd2};

    vecs[0]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 1'b0, 16'd0, 8'd0};
    vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[4]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[5]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[6]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[7]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[8]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd1, 8'd0};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 16'd1, 8'd0};
    vecs[10] = '{1'b1, 4'b0001, 4'b0000, 4'b0010, 4'b0001, 1'b1, 16'd2, 8'd0};
    vecs[11] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'd2, 8'd0};

    for (int i = 0; i < 7; i++) begin
      pk_mask = pvecs[i].mask;
      pk_ptr  = pvecs[i].ptr;
      #1;
      checkOutput($sformatf("pick%0d.found", i), 16'(pk_found), 16'(pvecs[i].found));
      if (pvecs[i].found) checkOutput($sformatf("pick%0d.idx", i), 16'(pk_idx), 16'(pvecs[i].idx));
    end

    doReset(1'b0, 4'b0001);
    checkAll("reset", 4'b0000, 4'b1000, 1'b0, 16'd0, 8'd0);

    // Press, cooldown with an ignored press, then a round-robin second shot.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].fire, vecs[i].dir, vecs[i].exists);
      checkAll($sformatf("vec%0d", i), vecs[i].shoot, vecs[i].sdir, vecs[i].busy,
               vecs[i].shots, vecs[i].dropped);
    end

    // Held button yields exactly one pulse; a later re-press goes to the next slot.
    doReset(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0001, 4'b0000);
    pulses = 0;
    first_pulse = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 4'b0001, 4'b0000);
      if (shoot_bullet != 4'b0000 && pulses == 0) first_pulse = shoot_bullet;
      pulses += $countones(shoot_bullet);
    end
    checkOutput("hold.pulses", 16'(pulses), 16'd1);
    checkOutput("hold.slot", 16'(first_pulse), 16'b0001);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    checkAll("repress", 4'b0010, 4'b0001, 1'b1, 16'd2, 8'd0);

    // All slots busy, then slot 2 frees while pending.
    doReset(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0001, 4'b1111);
    applyStimulus(1'b1, 4'b0001, 4'b1111);
    checkAll("pend.enter", 4'b0000, 4'b1000, 1'b1, 16'd0, 8'd0);
    applyStimulus(1'b0, 4'b0001, 4'b1111);
    checkAll("pend.wait", 4'b0000, 4'b1000, 1'b1, 16'd0, 8'd0);
    applyStimulus(1'b0, 4'b0001, 4'b1011);
    checkAll("pend.fire", 4'b0100, 4'b0001, 1'b1, 16'd1, 8'd0);

    // Presses with no free slot are dropped after the pending window; counter saturates.
    doReset(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0001, 4'b1111);
    applyStimulus(1'b1, 4'b0001, 4'b1111);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0001, 4'b1111);
    checkAll("drop.last", 4'b0000, 4'b1000, 1'b1, 16'd0, 8'd0);
    applyStimulus(1'b0, 4'b0001, 4'b1111);
    checkAll("drop.one", 4'b0000, 4'b1000, 1'b0, 16'd0, 8'd1);
    for (int k = 0; k < 299; k++) begin
      applyStimulus(1'b1, 4'b0001, 4'b1111);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0001, 4'b1111);
      if (k == 0) checkOutput("drop.two", 16'(dropped_shots), 16'd2);
    end
    checkAll("drop.sat", 4'b0000, 4'b1000, 1'b0, 16'd0, 8'd255);

    // Invalid direction keeps the last valid one; reset in cooldown with button held.
    doReset(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    applyStimulus(1'b0, 4'b1010, 4'b0000);
    applyStimulus(1'b1, 4'b1010, 4'b0000);
    checkAll("dir.keep", 4'b0001, 4'b0100, 1'b1, 16'd1, 8'd0);
    applyStimulus(1'b1, 4'b1010, 4'b0000);
    applyStimulus(1'b1, 4'b1010, 4'b0000);
    Reset = 1'b1;
    tick();
    checkAll("rst.cool", 4'b0000, 4'b1000, 1'b0, 16'd0, 8'd0);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 4'b1010, 4'b0000);
      pulses += $countones(shoot_bullet);
    end
    checkOutput("rst.held.pulses", 16'(pulses), 16'd0);
    applyStimulus(1'b0, 4'b1010, 4'b0000);
    applyStimulus(1'b1, 4'b1010, 4'b0000);
    checkAll("rst.repress", 4'b0001, 4'b1000, 1'b1, 16'd1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
